shift_seq_ctrl: RTL

- Multi-cycle sequencer for the CPU shift datapath: performs SLL/SRL/SRA/ROTR on a 32-bit operand using shamt (instruction bits [10:6] or rs[4:0], chosen upstream).
- Applies one binary-weighted barrel stage per clock, so the shared stage logic stays one stage deep.
- Sits beside the ALU. The multi-cycle control FSM pulses start, holds the pipeline while busy=1, and writes back res when done=1.

---
 rtl/shift_seq_ctrl_pkg.sv | 15 +
 rtl/shift_stage.sv | 37 +++
 rtl/shift_seq_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: op codes and FSM states.
package shift_seq_ctrl_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// One binary-weighted barrel stage: shifts din by 2^k according to op when en is set.
module shift_stage
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   k,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] dout
);

  // Only k < SHW is meaningful; 2^k then always fits in SHW bits.
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] sra_ext;
  logic [2*WIDTH-1:0] rot_ext;

  assign amt     = SHW'(1) << k;
  assign sra_ext = {{WIDTH{sign}}, din} >> amt;
  assign rot_ext = {din, din} >> amt;

  always_comb begin
    dout = din;
    if (en) begin
      case (op)
        OP_SLL:  dout = din << amt;
        OP_SRL:  dout = din >> amt;
        OP_SRA:  dout = sra_ext[WIDTH-1:0];
        default: dout = rot_ext[WIDTH-1:0];
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one barrel stage per clock, fixed SHW-cycle latency,
// optional single-cycle completion for zero shift amounts.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter int FAST_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  state_t           state_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [1:0]       op_reg;
  logic [SHW-1:0]   shamt_reg;
  logic             sign_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] res_reg;
  logic             done_reg;

  logic [SHW-1:0]   shamt_sh;
  logic [WIDTH-1:0] stage_out;
  logic             accept;
  logic             last_stage;

  assign shamt_sh   = shamt_reg >> cnt_reg;
  assign accept     = start && !abort && (state_reg != S_SHIFT);
  assign last_stage = (cnt_reg == SHW'(SHW - 1));

  shift_stage #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_stage (
    .din (acc_reg),
    .k   (cnt_reg),
    .en  (shamt_sh[0]),
    .op  (op_reg),
    .sign(sign_reg),
    .dout(stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      shamt_reg <= '0;
      sign_reg  <= 1'b0;
      acc_reg   <= '0;
      res_reg   <= '0;
      done_reg  <= 1'b0;
    end else if (abort) begin
      // Flush: the in-flight accumulator is simply abandoned, res is untouched.
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_SHIFT: begin
          acc_reg <= stage_out;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_stage) begin
            res_reg   <= stage_out;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
          if (accept) begin
            op_reg    <= op;
            shamt_reg <= shamt;
            sign_reg  <= a[WIDTH-1];
            acc_reg   <= a;
            cnt_reg   <= '0;
            if ((FAST_ZERO != 0) && (shamt == '0)) begin
              res_reg   <= a;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_SHIFT;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state_reg == S_SHIFT);
  assign done = done_reg;
  assign res  = res_reg;

endmodule
